// File: rtl/bcd_mod_stream_pkg.sv
// Shared definitions for the digit-serial BCD residue checker.
package bcd_mod_stream_pkg;

    localparam int BCD_MAX = 9;

    typedef enum logic [0:0] {
        ACC  = 1'b0,
        DONE = 1'b1
    } state_t;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/bcd_mod_step.sv
// One Horner step of a decimal residue: (10*residue + digit) mod MODULUS.
module bcd_mod_step
    import bcd_mod_stream_pkg::*;
#(
    parameter int  MODULUS = 3,
    localparam int RW      = (clog2(MODULUS) > 1) ? clog2(MODULUS) : 1
) (
    input  logic [RW-1:0] residue,
    input  logic [3:0]    digit,
    output logic [RW-1:0] next_residue
);

    // 10*(MODULUS-1)+9 < 10*MODULUS, so IW bits can never overflow
    localparam int IW = clog2(10 * MODULUS);

    logic [IW-1:0] digit_w;
    logic [IW-1:0] acc;

    always_comb begin
        digit_w      = (digit > 4'(BCD_MAX)) ? '0 : IW'(digit);
        acc          = IW'(residue) * IW'(10) + digit_w;
        next_residue = RW'(acc % IW'(MODULUS));
    end

endmodule

// File: rtl/bcd_mod_stream.sv
// Digit-serial BCD divisibility checker: MSD-first digits in, one residue result per number out.
module bcd_mod_stream
    import bcd_mod_stream_pkg::*;
#(
    parameter int  MODULUS = 3,
    parameter int  DIGITS  = 8,
    localparam int RW      = (clog2(MODULUS) > 1) ? clog2(MODULUS) : 1,
    localparam int CW      = clog2(DIGITS + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [3:0]    in_digit,
    input  logic          in_valid,
    input  logic          in_last,
    output logic          in_ready,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [RW-1:0] out_residue,
    output logic          out_divisible,
    output logic [CW-1:0] out_digits,
    output logic          out_error
);

    state_t        state;
    logic [RW-1:0] residue_p0;
    logic [RW-1:0] residue_nxt;
    logic [CW-1:0] count_p0;
    logic [CW-1:0] count_nxt;
    logic          err_p0;
    logic          err_nxt;
    logic          accept;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
        return (c == CW'(DIGITS)) ? c : c + CW'(1);
    endfunction

    bcd_mod_step #(.MODULUS(MODULUS)) u_step (
        .residue      (residue_p0),
        .digit        (in_digit),
        .next_residue (residue_nxt)
    );

    assign in_ready  = (state == ACC);
    assign out_valid = (state == DONE);

    always_comb begin
        accept    = in_valid && in_ready;
        count_nxt = sat_inc(count_p0);
        err_nxt   = err_p0 || (in_digit > 4'(BCD_MAX)) || (count_p0 == CW'(DIGITS));
    end

    // Accumulate stage; the result registers load from the updated values on the last digit
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ACC;
            residue_p0    <= '0;
            count_p0      <= '0;
            err_p0        <= 1'b0;
            out_residue   <= '0;
            out_divisible <= 1'b0;
            out_digits    <= '0;
            out_error     <= 1'b0;
        end else begin
            case (state)
                ACC: begin
                    if (accept) begin
                        residue_p0 <= residue_nxt;
                        count_p0   <= count_nxt;
                        err_p0     <= err_nxt;
                        if (in_last) begin
                            state         <= DONE;
                            out_residue   <= residue_nxt;
                            out_divisible <= (residue_nxt == '0) && !err_nxt;
                            out_digits    <= count_nxt;
                            out_error     <= err_nxt;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state      <= ACC;
                        residue_p0 <= '0;
                        count_p0   <= '0;
                        err_p0     <= 1'b0;
                    end
                end
                default: state <= ACC;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_mod_stream.sv
// Bench for bcd_mod_stream: a MODULUS=3 and a MODULUS=7 instance driven in lockstep.
module tb_bcd_mod_stream;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] in_digit;
    logic       in_valid;
    logic       in_last;
    logic       out_ready;

    logic       in_ready_a, out_valid_a, out_divisible_a, out_error_a;
    logic [1:0] out_residue_a;
    logic [3:0] out_digits_a;
    logic       in_ready_b, out_valid_b, out_divisible_b, out_error_b;
    logic [2:0] out_residue_b;
    logic [3:0] out_digits_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    bcd_mod_stream #(.MODULUS(3), .DIGITS(8)) dut_a (
        .clk(clk), .rst(rst), .in_digit(in_digit), .in_valid(in_valid),
        .in_last(in_last), .in_ready(in_ready_a), .out_valid(out_valid_a),
        .out_ready(out_ready), .out_residue(out_residue_a),
        .out_divisible(out_divisible_a), .out_digits(out_digits_a),
        .out_error(out_error_a)
    );

    bcd_mod_stream #(.MODULUS(7), .DIGITS(8)) dut_b (
        .clk(clk), .rst(rst), .in_digit(in_digit), .in_valid(in_valid),
        .in_last(in_last), .in_ready(in_ready_b), .out_valid(out_valid_b),
        .out_ready(out_ready), .out_residue(out_residue_b),
        .out_divisible(out_divisible_b), .out_digits(out_digits_b),
        .out_error(out_error_b)
    );

    typedef struct packed {
        logic [47:0] dig;
        logic [3:0]  nd;
        logic [3:0]  hold;
        logic [7:0]  r3;
        logic [7:0]  r7;
        logic [7:0]  cnt;
        logic        err;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: evaluate the whole decimal number, then take the remainders
    function automatic void model(input logic [47:0] dig, input int nd, output int r3,
                                  output int r7, output int cnt, output bit err);
        longint value;
        int d;
        value = 0;
        err   = (nd > 8);
        for (int i = 0; i < nd; i++) begin
            d = int'(dig[4*(nd-1-i) +: 4]);
            if (d > 9) begin
                err = 1'b1;
                d   = 0;
            end
            value = value * 10 + longint'(d);
        end
        r3  = int'(value % 3);
        r7  = int'(value % 7);
        cnt = (nd > 8) ? 8 : nd;
    endfunction

    task automatic check_result(input string tag, input int r3, input int r7,
                                input int cnt, input bit err);
        check({tag, ".valid_a"}, out_valid_a, 1);
        check({tag, ".valid_b"}, out_valid_b, 1);
        check({tag, ".residue_a"}, out_residue_a, r3);
        check({tag, ".residue_b"}, out_residue_b, r7);
        check({tag, ".divisible_a"}, out_divisible_a, (r3 == 0) && !err);
        check({tag, ".divisible_b"}, out_divisible_b, (r7 == 0) && !err);
        check({tag, ".digits_a"}, out_digits_a, cnt);
        check({tag, ".digits_b"}, out_digits_b, cnt);
        check({tag, ".error_a"}, out_error_a, err);
        check({tag, ".error_b"}, out_error_b, err);
    endtask

    task automatic send_number(input string tag, input logic [47:0] dig, input int nd,
                               input int hold, input int r3, input int r7,
                               input int cnt, input bit err);
        int n;
        logic [1:0] s_res_a;
        logic [2:0] s_res_b;
        logic [3:0] s_dig_a;
        logic s_div_a, s_err_a;
        out_ready = (hold == 0);
        for (int i = 0; i < nd; i++) begin
            in_digit = dig[4*(nd-1-i) +: 4];
            in_valid = 1'b1;
            in_last  = (i == nd - 1);
            n = 0;
            while (!(in_ready_a && in_ready_b) && n < 20) begin
                @(negedge clk);
                n++;
            end
            check({tag, ".in_ready"}, in_ready_a && in_ready_b, 1);
            @(negedge clk);
            if (i != nd - 1) check({tag, ".early_valid"}, out_valid_a | out_valid_b, 0);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        // One edge after the last accept the result must already be presented
        check_result(tag, r3, r7, cnt, err);
        s_res_a = out_residue_a; s_res_b = out_residue_b; s_dig_a = out_digits_a;
        s_div_a = out_divisible_a; s_err_a = out_error_a;
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1;
            in_digit = 4'd5;
            in_last  = 1'b1;
            @(negedge clk);
            check({tag, ".hold_in_ready"}, in_ready_a | in_ready_b, 0);
            check({tag, ".hold_valid"}, out_valid_a && out_valid_b, 1);
            check({tag, ".hold_stable_a"}, {s_res_a, s_dig_a, s_div_a, s_err_a},
                  {out_residue_a, out_digits_a, out_divisible_a, out_error_a});
            check({tag, ".hold_stable_b"}, s_res_b, out_residue_b);
        end
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check({tag, ".release_ready"}, in_ready_a && in_ready_b, 1);
        check({tag, ".release_valid"}, out_valid_a | out_valid_b, 0);
        out_ready = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int r3, r7, cnt, nd, hold;
        bit err;
        logic [47:0] dig;
        logic [3:0] d;

        //        dig               nd     hold   r3     r7     cnt    err
        vecs[0] = '{48'h123456,     4'd6, 4'd0, 8'd0, 8'd4, 8'd6, 1'b0};
        vecs[1] = '{48'h1002,       4'd4, 4'd0, 8'd0, 8'd1, 8'd4, 1'b0};
        vecs[2] = '{48'h1001,       4'd4, 4'd0, 8'd2, 8'd0, 8'd4, 1'b0};
        vecs[3] = '{48'h4A5,        4'd3, 4'd0, 8'd0, 8'd6, 8'd3, 1'b1};
        vecs[4] = '{48'h333333333,  4'd9, 4'd5, 8'd0, 8'd4, 8'd8, 1'b1};
        vecs[5] = '{48'h99999999,   4'd8, 4'd2, 8'd0, 8'd1, 8'd8, 1'b0};
        vecs[6] = '{48'h9,          4'd1, 4'd0, 8'd0, 8'd2, 8'd1, 1'b0};
        vecs[7] = '{48'hF,          4'd1, 4'd0, 8'd0, 8'd0, 8'd1, 1'b1};
        vecs[8] = '{48'h0,          4'd1, 4'd1, 8'd0, 8'd0, 8'd1, 1'b0};

        rst = 1'b1; in_digit = 4'd0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("reset.in_ready", in_ready_a && in_ready_b, 1);
        check("reset.out_valid", out_valid_a | out_valid_b, 0);
        check("reset.data_a", {out_residue_a, out_divisible_a, out_digits_a, out_error_a}, 0);
        check("reset.data_b", {out_residue_b, out_divisible_b, out_digits_b, out_error_b}, 0);

        for (int v = 0; v < 9; v++) begin
            send_number($sformatf("vec%0d", v), vecs[v].dig, int'(vecs[v].nd),
                        int'(vecs[v].hold), int'(vecs[v].r3), int'(vecs[v].r7),
                        int'(vecs[v].cnt), vecs[v].err);
        end

        // Reset in the middle of a number discards it
        for (int i = 0; i < 3; i++) begin
            in_digit = 4'd5; in_valid = 1'b1; in_last = 1'b0;
            @(negedge clk);
        end
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst.in_ready", in_ready_a && in_ready_b, 1);
        check("midrst.data_a", {out_residue_a, out_divisible_a, out_digits_a, out_error_a}, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("midrst.no_valid", out_valid_a | out_valid_b, 0);
        end
        send_number("after_rst", 48'h9, 1, 0, 0, 2, 1, 1'b0);

        for (int t = 0; t < 30; t++) begin
            nd   = int'($urandom_range(1, 10));
            hold = int'($urandom_range(0, 3));
            dig  = '0;
            for (int i = 0; i < nd; i++) begin
                if ($urandom_range(0, 11) == 0) d = 4'($urandom_range(10, 15));
                else d = 4'($urandom_range(0, 9));
                dig = {dig[43:0], d};
            end
            model(dig, nd, r3, r7, cnt, err);
            send_number($sformatf("rnd%0d", t), dig, nd, hold, r3, r7, cnt, err);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bcd_mod_stream.md
Name: bcd_mod_stream

Overview:
- Digit-serial successor to the combinational divide-by-3 checker.
- Accepts BCD digits one per cycle, most significant digit (MSD) first, over a valid/ready handshake.
- Keeps a running residue modulo a parameterised divisor and reports the residue, divisibility flag, digit count and error status per number over a second valid/ready handshake.
- Sits between a BCD digit source (keypad/UART decoder) and display or decision logic.

Parameters:
- MODULUS, 3, divisor; legal range 2..99.
- DIGITS, 8, maximum digits per number; legal range 1..255.
- RW, derived = max(1, clog2(MODULUS)), residue width.
- CW, derived = clog2(DIGITS+1), digit-count width.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- in_digit  input  4  BCD digit; legal values 0..9
- in_valid  input  1  in_digit/in_last valid
- in_last  input  1  current digit is the least significant digit of the number
- in_ready  output  1  block accepts a digit this cycle
- out_valid  output  1  result available
- out_ready  input  1  consumer takes the result
- out_residue  output  RW  number mod MODULUS
- out_divisible  output  1  out_residue==0 and out_error==0
- out_digits  output  CW  digits accepted, saturating at DIGITS
- out_error  output  1  illegal digit or more than DIGITS digits seen

Behaviour:
- Interface: one clock (clk); reset (rst) is synchronous and active-high.
- Reset values:
  - state=ACC, residue=0, count=0, err=0.
  - in_ready=1, out_valid=0.
  - All out_* data outputs=0.
- Reset mid-number discards the partial number with no result emitted.
- States:
  - ACC: in_ready=1, out_valid=0.
  - DONE: in_ready=0, out_valid=1.
- Accept rule: a digit is taken when in_valid && in_ready.
- Update on accept:
  - residue <= (10*residue + in_digit) mod MODULUS.
  - Intermediate width is clog2(10*MODULUS) bits; no overflow is possible.
- Illegal digit (in_digit > 9):
  - err <= 1 (sticky).
  - The digit is treated as 0 in the residue update.
  - Still counted.
- Count:
  - count increments on each accept and saturates at DIGITS.
  - Accepting a digit while count==DIGITS sets err.
- Transition ACC->DONE: on accept with in_last=1.
  - Outputs are registered from the updated residue, count and err.
  - Latency: out_valid rises on the cycle after the last digit is accepted.
- Single-digit numbers (first digit with in_last=1) are legal.
- DONE holds all out_* stable while out_ready=0.
- Transition DONE->ACC: on out_valid && out_ready.
  - residue, count and err are cleared.
  - in_ready=1 on the next cycle.
  - Minimum gap between numbers is one cycle.
- Error results: when out_error=1, out_divisible is forced to 0; out_residue reflects the digits as computed.
- in_valid with in_ready=0 is ignored; the source must hold its data.
- Throughput: one digit per cycle within a number.

Decomposition:
- Shared package holds:
  - BCD_MAX=9.
  - A state enum {ACC, DONE}.
  - A clog2 function used by RW/CW.
- One natural sub-module: bcd_mod_step.
  - Combinational, parameter MODULUS.
  - Inputs residue[RW] and digit[4]; output next residue.
  - Maps illegal digits to 0.
  - Reusable by a future parallel multi-digit variant.
- Top level holds the FSM, counter, error flag and output registers.

Test Plan:
1. MODULUS=3: digits 1,2,3,4,5,6 (last on 6), out_ready=1 -> out_residue=0, out_divisible=1, out_digits=6, out_error=0, out_valid one cycle after last accept.
2. MODULUS=7: digits 1,0,0,2 -> residue 1002 mod 7 = 1, out_divisible=0. Then digits 1,0,0,1 -> residue 0, divisible=1, one-cycle gap between numbers.
3. MODULUS=3: digits 4,0xA,5 -> out_error=1, out_divisible=0, out_digits=3, out_residue=(405 mod 3)=0.
4. DIGITS=8, MODULUS=3: nine digits of 3 -> out_error=1, out_digits=8, out_divisible=0.
5. Backpressure: out_ready=0 for 5 cycles after result -> out_* stable, in_ready=0, extra in_valid ignored. Release out_ready -> next number processed correctly from residue 0.
6. rst asserted after 3 of 5 digits -> no out_valid. A following number 9 (single digit, MODULUS=3) -> residue 0, divisible=1, out_digits=1.
